// File: rtl/mm_pkg.sv
// Shared types and sizing for the 3x3 matrix multiplier stream loader.
package mm_pkg;

    localparam int ELEM_W       = 8;
    localparam int DIM          = 3;
    localparam int NUM_ELEMS    = DIM * DIM;
    localparam int NUM_IN_BYTES = 2 * NUM_ELEMS;
    localparam int MAT_W        = NUM_ELEMS * ELEM_W;
    localparam int CNT_W        = $clog2(NUM_IN_BYTES);
    localparam int IDX_W        = $clog2(NUM_ELEMS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/mm_out_serializer.sv
// Holds the captured 72-bit result and streams it out one byte per
// valid/ready transfer, element 0 first.
module mm_out_serializer
    import mm_pkg::*;
(
    input  logic               Clock,
    input  logic               reset_n,
    input  logic               capture,
    input  logic [MAT_W-1:0]   capture_data,
    output logic [ELEM_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               last
);

    logic [MAT_W-1:0] result_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             valid_reg;

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            result_reg <= '0;
            idx_reg    <= '0;
            valid_reg  <= 1'b0;
        end else if (capture) begin
            result_reg <= capture_data;
            idx_reg    <= '0;
            valid_reg  <= 1'b1;
        end else if (valid_reg && out_ready) begin
            if (idx_reg == IDX_W'(NUM_ELEMS - 1)) begin
                idx_reg   <= '0;
                valid_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    assign out_data  = result_reg[idx_reg*ELEM_W +: ELEM_W];
    assign out_valid = valid_reg;
    // Final transfer of the job; feeds the parent FSM only, never a port.
    assign last      = valid_reg && out_ready && (idx_reg == IDX_W'(NUM_ELEMS - 1));

endmodule

// File: rtl/matrix_stream_loader.sv
// Byte-stream loader/unloader around the 3x3 matrix multiplier.
// Optional RUN watchdog compiled in with MM_LOADER_WATCHDOG_EN.
module matrix_stream_loader
    import mm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               Clock,
    input  logic               reset_n,
    input  logic [ELEM_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ELEM_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAT_W-1:0]   mm_A,
    output logic [MAT_W-1:0]   mm_B,
    output logic               mm_reset,
    output logic               mm_enable,
    input  logic [MAT_W-1:0]   mm_C,
    input  logic               mm_done,
    output logic               busy,
    output logic               timeout_err
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] byte_cnt_reg;
    logic [MAT_W-1:0] a_reg, b_reg;
    logic             accept;
    logic             capture;
    logic             ser_last;
    logic             wd_expire;

    assign accept = in_valid && (state_reg == LOAD);

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        in_ready   = 1'b0;
        mm_reset   = 1'b1;
        mm_enable  = 1'b0;
        case (state_reg)
            IDLE:  state_next = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (accept && byte_cnt_reg == CNT_W'(NUM_IN_BYTES - 1)) begin
                    state_next = KICK;
                end
            end
            KICK:  state_next = RUN;
            RUN: begin
                mm_reset  = 1'b0;
                mm_enable = 1'b1;
                if (mm_done) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                end else if (wd_expire) begin
                    state_next = LOAD;
                end
            end
            DRAIN: begin
                if (ser_last) begin
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand slots are overwritten in place; they keep the last job until rewritten.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_reg <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                if (byte_cnt_reg == CNT_W'(i)) begin
                    a_reg[i*ELEM_W +: ELEM_W] <= in_data;
                end
                if (byte_cnt_reg == CNT_W'(i + NUM_ELEMS)) begin
                    b_reg[i*ELEM_W +: ELEM_W] <= in_data;
                end
            end
            if (byte_cnt_reg == CNT_W'(NUM_IN_BYTES - 1)) begin
                byte_cnt_reg <= '0;
            end else begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
        end
    end

    assign mm_A = a_reg;
    assign mm_B = b_reg;
    assign busy = !((state_reg == LOAD) && (byte_cnt_reg == '0));

    mm_out_serializer u_serializer (
        .Clock        (Clock),
        .reset_n      (reset_n),
        .capture      (capture),
        .capture_data (mm_C),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .last         (ser_last)
    );

`ifdef MM_LOADER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_err_reg;

    assign wd_expire = (state_reg == RUN) && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == RUN && !mm_done && !wd_expire) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end else begin
                wd_cnt_reg <= '0;
            end
            if (state_reg == RUN && !mm_done && wd_expire) begin
                timeout_err_reg <= 1'b1;
            end else if (state_next == KICK && state_reg != KICK) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule
